// File: rtl/pwm_duty_ctrl_if.sv
// Button inputs and duty/mode outputs of the PWM duty-cycle controller.
//   btn_up_i / btn_dn_i / btn_mode_i : raw asynchronous push-buttons
//   duty_o     : current duty value (7 bits)
//   mode_o     : current controller mode (00 MANUAL, 01 BREATHE_UP, 10 BREATHE_DN)
//   duty_upd_o : one-cycle pulse in the first cycle duty_o holds a new value
interface pwm_duty_ctrl_if;
  localparam int unsigned DUTY_W = 7;
  localparam int unsigned MODE_W = 2;

  logic              btn_up_i;
  logic              btn_dn_i;
  logic              btn_mode_i;
  logic [DUTY_W-1:0] duty_o;
  logic [MODE_W-1:0] mode_o;
  logic              duty_upd_o;

  // Controller side
  modport slave (
    input  btn_up_i, btn_dn_i, btn_mode_i,
    output duty_o, mode_o, duty_upd_o
  );

  // Button/board side
  modport master (
    output btn_up_i, btn_dn_i, btn_mode_i,
    input  duty_o, mode_o, duty_upd_o
  );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller for the PWM/LED datapath: debounces up/down/mode
// buttons and sequences the shared 7-bit duty value, either by manual steps
// or by an automatic up/down "breathing" ramp.
//   clk   : system clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : buttons in, duty/mode/update-pulse out (all outputs registered)
module pwm_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STEP_CYCLES     = 1000000,
  parameter int unsigned DUTY_MAX        = 99,
  parameter int unsigned STEP            = 1
) (
  input  logic            clk,
  input  logic            rst_i,
  pwm_duty_ctrl_if.slave  bus
);

  localparam int unsigned DUTY_W  = 7;
  localparam int unsigned ARITH_W = 8;
  localparam int unsigned N_BTN   = 3;
  localparam int unsigned DB_CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TM_CW   = $clog2(STEP_CYCLES);

  // Button bit positions
  localparam int unsigned B_UP   = 0;
  localparam int unsigned B_DN   = 1;
  localparam int unsigned B_MODE = 2;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_BUP    = 2'b01,
    ST_BDN    = 2'b10
  } state_e;

  // ---------------------------------------------------------------------
  // Input path: 2-flop synchroniser, stability counter, rising-edge pulse
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] db_q, db_d;
  logic [N_BTN-1:0] db_prev_q, db_prev_d;
  logic [DB_CW-1:0] cnt_q [N_BTN];
  logic [DB_CW-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] press;

  assign btn_raw = {bus.btn_mode_i, bus.btn_dn_i, bus.btn_up_i};

  // Debounce next-state: counter runs only while synced level differs from db
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_CW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------
  // Duty sequencer
  // ---------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [TM_CW-1:0]   timer_q, timer_d;
  logic               upd_q, upd_d;

  logic               tc;
  logic [ARITH_W-1:0] duty_ext;
  logic [ARITH_W-1:0] duty_sum;
  logic [DUTY_W-1:0]  duty_inc;
  logic [DUTY_W-1:0]  duty_dec;

  // Saturating step arithmetic, done in 8 bits so the sum cannot wrap
  assign tc       = (timer_q == TM_CW'(STEP_CYCLES - 1));
  assign duty_ext = {1'b0, duty_q};
  assign duty_sum = duty_ext + ARITH_W'(STEP);
  assign duty_inc = (duty_sum > ARITH_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : duty_sum[DUTY_W-1:0];
  assign duty_dec = (duty_ext < ARITH_W'(STEP)) ? '0 : DUTY_W'(duty_ext - ARITH_W'(STEP));

  // State register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= ST_MANUAL;
      duty_q  <= '0;
      timer_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      timer_q <= timer_d;
      upd_q   <= upd_d;
    end
  end

  // Next-state logic; a mode press always takes priority
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_MANUAL: begin
        if (press[B_MODE]) begin
          state_d = (duty_q == DUTY_W'(DUTY_MAX)) ? ST_BDN : ST_BUP;
        end
      end
      ST_BUP: begin
        if (press[B_MODE]) begin
          state_d = ST_MANUAL;
        end else if (tc && (duty_inc == DUTY_W'(DUTY_MAX))) begin
          state_d = ST_BDN;
        end
      end
      ST_BDN: begin
        if (press[B_MODE]) begin
          state_d = ST_MANUAL;
        end else if (tc && (duty_dec == '0)) begin
          state_d = ST_BUP;
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  // Datapath/output logic; timer idles at 0 outside the breathe ramps
  always_comb begin
    duty_d  = duty_q;
    timer_d = '0;
    unique case (state_q)
      ST_MANUAL: begin
        if (!press[B_MODE]) begin
          if (press[B_UP] && !press[B_DN]) begin
            duty_d = duty_inc;
          end else if (press[B_DN] && !press[B_UP]) begin
            duty_d = duty_dec;
          end
        end
      end
      ST_BUP: begin
        if (!press[B_MODE]) begin
          timer_d = tc ? '0 : timer_q + TM_CW'(1);
          if (tc) duty_d = duty_inc;
        end
      end
      ST_BDN: begin
        if (!press[B_MODE]) begin
          timer_d = tc ? '0 : timer_q + TM_CW'(1);
          if (tc) duty_d = duty_dec;
        end
      end
      default: begin
        duty_d  = duty_q;
        timer_d = '0;
      end
    endcase
    upd_d = (duty_d != duty_q);
  end

  assign bus.duty_o     = duty_q;
  assign bus.mode_o     = state_q;
  assign bus.duty_upd_o = upd_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl: STEP=1 instance for the main scenarios,
// STEP=3 instance for the clamped breathe turn-around.
module tb_pwm_duty_ctrl;

  localparam int unsigned B_UP   = 0;
  localparam int unsigned B_DN   = 1;
  localparam int unsigned B_MODE = 2;

  logic clk;
  logic rst_i;
  int   n_checks;
  int   n_fail;
  int   upd_cnt;
  int   u0;

  pwm_duty_ctrl_if bif ();
  pwm_duty_ctrl_if bif3 ();

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES(4), .STEP_CYCLES(5), .DUTY_MAX(99), .STEP(1)
  ) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bif)
  );

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES(4), .STEP_CYCLES(5), .DUTY_MAX(99), .STEP(3)
  ) dut3 (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bif3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count update pulses of the STEP=1 instance
  always @(negedge clk) if (bif.duty_upd_o === 1'b1) upd_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int d, input int unsigned b, input logic v);
    if (d == 0) begin
      case (b)
        B_UP:    bif.btn_up_i   = v;
        B_DN:    bif.btn_dn_i   = v;
        default: bif.btn_mode_i = v;
      endcase
    end else begin
      case (b)
        B_UP:    bif3.btn_up_i   = v;
        B_DN:    bif3.btn_dn_i   = v;
        default: bif3.btn_mode_i = v;
      endcase
    end
  endtask

  task automatic press(input int d, input int unsigned b);
    set_btn(d, b, 1'b1);
    cyc(8);
    set_btn(d, b, 1'b0);
    cyc(8);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    upd_cnt  = 0;
    rst_i    = 1'b1;
    bif.btn_up_i  = 1'b0; bif.btn_dn_i  = 1'b0; bif.btn_mode_i  = 1'b0;
    bif3.btn_up_i = 1'b0; bif3.btn_dn_i = 1'b0; bif3.btn_mode_i = 1'b0;

    // 1: reset with buttons toggling
    for (int i = 0; i < 3; i++) begin
      bif.btn_up_i   = i[0];
      bif.btn_dn_i   = ~i[0];
      bif.btn_mode_i = i[0];
      cyc(1);
      check_eq("rst_duty", 32'(bif.duty_o), 0);
      check_eq("rst_mode", 32'(bif.mode_o), 0);
      check_eq("rst_upd", 32'(bif.duty_upd_o), 0);
    end
    bif.btn_up_i = 1'b0; bif.btn_dn_i = 1'b0; bif.btn_mode_i = 1'b0;
    rst_i = 1'b0;
    cyc(10);
    check_eq("post_rst_duty", 32'(bif.duty_o), 0);
    check_eq("post_rst_mode", 32'(bif.mode_o), 0);
    check_eq("post_rst_upd_cnt", 32'(upd_cnt), 0);

    // 2: glitch of 3 cycles rejected
    bif.btn_up_i = 1'b1;
    cyc(3);
    bif.btn_up_i = 1'b0;
    cyc(12);
    check_eq("glitch_duty", 32'(bif.duty_o), 0);
    check_eq("glitch_upd_cnt", 32'(upd_cnt), 0);

    // 2: long press, latency of 7 edges, single step
    bif.btn_up_i = 1'b1;
    cyc(6);
    check_eq("lat6_duty", 32'(bif.duty_o), 0);
    cyc(1);
    check_eq("lat7_duty", 32'(bif.duty_o), 1);
    check_eq("lat7_upd", 32'(bif.duty_upd_o), 1);
    cyc(1);
    check_eq("lat8_upd", 32'(bif.duty_upd_o), 0);
    cyc(12);
    bif.btn_up_i = 1'b0;
    cyc(8);
    check_eq("hold_duty", 32'(bif.duty_o), 1);
    check_eq("hold_upd_cnt", 32'(upd_cnt), 1);

    // 3: saturation at top
    for (int i = 0; i < 98; i++) press(0, B_UP);
    check_eq("ramp99_duty", 32'(bif.duty_o), 99);
    u0 = upd_cnt;
    press(0, B_UP);
    check_eq("sat_hi_duty", 32'(bif.duty_o), 99);
    check_eq("sat_hi_upd", 32'(upd_cnt), 32'(u0));

    // 3: saturation at bottom
    rst_i = 1'b1;
    cyc(3);
    rst_i = 1'b0;
    cyc(2);
    check_eq("rst2_duty", 32'(bif.duty_o), 0);
    u0 = upd_cnt;
    press(0, B_DN);
    check_eq("sat_lo_duty", 32'(bif.duty_o), 0);
    check_eq("sat_lo_upd", 32'(upd_cnt), 32'(u0));

    // 3: simultaneous up+dn at 50
    for (int i = 0; i < 50; i++) press(0, B_UP);
    check_eq("ramp50_duty", 32'(bif.duty_o), 50);
    u0 = upd_cnt;
    bif.btn_up_i = 1'b1;
    bif.btn_dn_i = 1'b1;
    cyc(8);
    bif.btn_up_i = 1'b0;
    bif.btn_dn_i = 1'b0;
    cyc(8);
    check_eq("both_duty", 32'(bif.duty_o), 50);
    check_eq("both_upd", 32'(upd_cnt), 32'(u0));

    // 4: breathe bounce from 97
    for (int i = 0; i < 47; i++) press(0, B_UP);
    check_eq("ramp97_duty", 32'(bif.duty_o), 97);
    bif.btn_mode_i = 1'b1;
    cyc(7);
    check_eq("bup_mode", 32'(bif.mode_o), 1);
    check_eq("bup_entry_duty", 32'(bif.duty_o), 97);
    check_eq("bup_entry_upd", 32'(bif.duty_upd_o), 0);
    bif.btn_mode_i = 1'b0;
    cyc(4);
    check_eq("bup_t4_duty", 32'(bif.duty_o), 97);
    cyc(1);
    check_eq("bup_t5_duty", 32'(bif.duty_o), 98);
    check_eq("bup_t5_mode", 32'(bif.mode_o), 1);
    cyc(5);
    check_eq("bup_t10_duty", 32'(bif.duty_o), 99);
    check_eq("bup_t10_mode", 32'(bif.mode_o), 2);
    cyc(5);
    check_eq("bdn_t15_duty", 32'(bif.duty_o), 98);
    check_eq("bdn_t15_mode", 32'(bif.mode_o), 2);

    // 5: exit breathe mid-ramp (auto step at +5, mode lands at +7)
    bif.btn_mode_i = 1'b1;
    cyc(7);
    check_eq("exit_mode", 32'(bif.mode_o), 0);
    check_eq("exit_duty", 32'(bif.duty_o), 97);
    bif.btn_mode_i = 1'b0;
    cyc(15);
    check_eq("idle_duty", 32'(bif.duty_o), 97);
    press(0, B_UP);
    check_eq("after_exit_up", 32'(bif.duty_o), 98);

    // 6: reach BREATHE_DN at 40, then reset with dn held
    press(0, B_UP);
    bif.btn_mode_i = 1'b1;
    cyc(7);
    check_eq("bdn_entry_mode", 32'(bif.mode_o), 2);
    check_eq("bdn_entry_duty", 32'(bif.duty_o), 99);
    bif.btn_mode_i = 1'b0;
    cyc(295);
    check_eq("bdn40_duty", 32'(bif.duty_o), 40);
    check_eq("bdn40_mode", 32'(bif.mode_o), 2);
    rst_i = 1'b1;
    bif.btn_dn_i = 1'b1;
    cyc(1);
    check_eq("midrst_duty", 32'(bif.duty_o), 0);
    check_eq("midrst_mode", 32'(bif.mode_o), 0);
    cyc(2);
    rst_i = 1'b0;
    u0 = upd_cnt;
    cyc(15);
    check_eq("dn_held_duty", 32'(bif.duty_o), 0);
    check_eq("dn_held_upd", 32'(upd_cnt), 32'(u0));
    bif.btn_dn_i = 1'b0;
    cyc(10);

    // 6: up held through reset release gives exactly one press
    rst_i = 1'b1;
    bif.btn_up_i = 1'b1;
    cyc(3);
    rst_i = 1'b0;
    u0 = upd_cnt;
    cyc(6);
    check_eq("up_held_pre", 32'(bif.duty_o), 0);
    cyc(1);
    check_eq("up_held_step", 32'(bif.duty_o), 1);
    cyc(20);
    check_eq("up_held_once", 32'(bif.duty_o), 1);
    check_eq("up_held_upd", 32'(upd_cnt), 32'(u0 + 1));
    bif.btn_up_i = 1'b0;
    cyc(8);

    // 4 variant: STEP=3, 96 -> 99 turns DN; mode press coincident with terminal count
    for (int i = 0; i < 32; i++) press(1, B_UP);
    check_eq("s3_ramp96", 32'(bif3.duty_o), 96);
    bif3.btn_mode_i = 1'b1;
    cyc(7);
    check_eq("s3_entry_mode", 32'(bif3.mode_o), 1);
    bif3.btn_mode_i = 1'b0;
    cyc(5);
    check_eq("s3_top_duty", 32'(bif3.duty_o), 99);
    check_eq("s3_top_mode", 32'(bif3.mode_o), 2);
    cyc(3);
    bif3.btn_mode_i = 1'b1;
    cyc(2);
    check_eq("s3_dn_duty", 32'(bif3.duty_o), 96);
    cyc(5);
    check_eq("s3_tie_mode", 32'(bif3.mode_o), 0);
    check_eq("s3_tie_duty", 32'(bif3.duty_o), 96);
    check_eq("s3_tie_upd", 32'(bif3.duty_upd_o), 0);
    bif3.btn_mode_i = 1'b0;
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
